alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational alu_unit between two requesters: port 0 = EX stage, port 1 = branch/address helper.
//  Requests use valid/ready handshakes. A round-robin arbiter grants one request per cycle and drives the ALU.
//  The ALU result is captured in a one-deep registered response buffer and returned with the winner's id.
//  Sits between the EX-stage issue logic and the single alu_unit instance.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width; must match the ALU
//  CTRL_WIDTH   4   alu_control width
//  FIXED_PRIO   0   0 = round-robin; 1 = port 0 always wins a conflict
// PORTS
//  clk           in   1           rising-edge clock (single clock domain)
//  rst_n         in   1           asynchronous, active-low reset
//  req0_valid    in   1           port 0 request valid
//  req0_ready    out  1           port 0 request accepted this cycle
//  req0_a        in   DATA_WIDTH  port 0 operand_a
//  req0_b        in   DATA_WIDTH  port 0 operand_b
//  req0_ctrl     in   CTRL_WIDTH  port 0 alu_control
//  req1_valid/req1_ready/req1_a/req1_b/req1_ctrl  same as port 0, for port 1
//  alu_operand_a out  DATA_WIDTH  to ALU operand_a
//  alu_operand_b out  DATA_WIDTH  to ALU operand_b
//  alu_control   out  CTRL_WIDTH  to ALU alu_control
//  alu_result    in   DATA_WIDTH  from ALU (combinational)
//  alu_zero      in   1           from ALU zero flag
//  rsp_valid     out  1           response buffer holds a result
//  rsp_ready     in   1           consumer accepts the response this cycle
//  rsp_id        out  1           requester that owns the response (0/1)
//  rsp_result    out  DATA_WIDTH  registered ALU result
//  rsp_zero      out  1           registered zero flag
// BEHAVIOUR
//  - Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, last_grant=1. Port 0 therefore wins the first conflict.
//  - can_issue = !rsp_valid | rsp_ready. Same-cycle drain plus refill is allowed, giving 1 result/cycle throughput.
//  - Grant (combinational), evaluated only when can_issue:
//    - only one valid -> that port
//    - both valid, FIXED_PRIO=0 -> port != last_grant
//    - both valid, FIXED_PRIO=1 -> port 0
//  - reqN_ready = can_issue & grant==N. At most one ready is high per cycle.
//  - ready never depends on the other port's ready, and never depends on data.
//  - A transfer occurs when valid & ready. The requester holds valid and its fields stable until ready.
//  - ALU drive:
//    - on a granted cycle, mux the winner's a/b/ctrl onto alu_operand_a/b and alu_control
//    - otherwise drive a=0, b=0, ctrl=4'b1111 (ALU default -> 0)
//  - On a transfer (posedge), capture: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=winner, rsp_valid<=1, last_grant<=winner.
//  - Latency: accepted in cycle N -> rsp_valid=1 with data in cycle N+1.
//  - Response hold: while rsp_valid & !rsp_ready, all rsp_* fields stay stable and both reqN_ready stay 0.
//  - rsp_valid & rsp_ready with no new transfer -> rsp_valid<=0. The rsp_* data fields keep their last value.
//  - last_grant changes only on a transfer. Idle cycles and stalls do not rotate priority.
//  - Starvation bound (round-robin): a continuously-valid port is granted within 2 issue opportunities.
//  - Async reset mid-operation: rst_n low immediately forces the reset values. Any buffered result is discarded, with no response.
//  - Reset is deasserted synchronously by the top level. No transfer occurs in the first cycle after release unless can_issue.
//  - No arithmetic in this block. Widths pass through unmodified.
// TESTING
//  1 Reset, req0 ADD a=5 b=3, rsp_ready=1:
//    -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
//  2 Both valid in the same cycle after reset (req0 ADD 1+1, req1 SUB 7-7):
//    -> cycle N: req0 granted; N+1: rsp 2/id0 and req1 granted; N+2: rsp 0/id1, rsp_zero=1.
//  3 rsp_ready=0 for 4 cycles with a response pending and req1 valid:
//    -> rsp_* constant and req0_ready=req1_ready=0;
//    -> the cycle rsp_ready rises, req1_ready=1; the new result appears the next cycle.
//  4 Both valid continuously for 6 transfers, rsp_ready=1:
//    -> rsp_id sequence 0,1,0,1,0,1, one per cycle;
//    -> same run with FIXED_PRIO=1 -> all 0.
//  5 Pull rst_n low while rsp_valid=1 and stalled:
//    -> rsp_valid=0 with no clock edge;
//    -> after release, the first conflict grants port 0.
//  6 SRA req1 a=32'h8000_0000 b=4, req0 idle:
//    -> rsp_result=32'hF800_0000, rsp_id=1, and the ALU ctrl bus reads 4'b1111 on idle cycles.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (port 0) and the branch/address helper (port 1).
// Latency: request accepted in cycle N, result visible on rsp_* in cycle N+1 (one registered stage).
// Backpressure: a pending response blocks both request ports until rsp_ready, with same-cycle drain+refill.
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 4,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic [CTRL_WIDTH-1:0] req0_ctrl,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   input  logic [CTRL_WIDTH-1:0] req1_ctrl,
   output logic [DATA_WIDTH-1:0] alu_operand_a,
   output logic [DATA_WIDTH-1:0] alu_operand_b,
   output logic [CTRL_WIDTH-1:0] alu_control,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero
);

   // All-ones control selects the ALU's default path, which yields zero.
   localparam logic [CTRL_WIDTH-1:0] ALU_CTRL_IDLE = '1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [CTRL_WIDTH-1:0] ctrl;
   } alu_req_t;

   alu_req_t req0_dat;
   alu_req_t req1_dat;
   alu_req_t alu_dat;

   logic can_issue;
   logic grant_vld;
   logic grant_id;
   logic last_grant;

   assign req0_dat = {req0_a, req0_b, req0_ctrl};
   assign req1_dat = {req1_a, req1_b, req1_ctrl};

   // The buffer slot is free if empty or being drained this very cycle.
   assign can_issue = !rsp_valid || rsp_ready;

   // Pick the winner: a lone requester wins; on conflict rotate away from the last winner,
   // or always favour port 0 when fixed priority is selected.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = FIXED_PRIO ? 1'b0 : ~last_grant;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign grant_vld  = can_issue && (req0_valid || req1_valid);
   assign req0_ready = grant_vld && !grant_id;
   assign req1_ready = grant_vld && grant_id;

   // Steer the winner onto the ALU; park the ALU on its zero-producing default otherwise.
   always_comb begin
      alu_dat.a    = '0;
      alu_dat.b    = '0;
      alu_dat.ctrl = ALU_CTRL_IDLE;
      if (grant_vld) begin
         alu_dat = grant_id ? req1_dat : req0_dat;
      end
   end

   assign alu_operand_a = alu_dat.a;
   assign alu_operand_b = alu_dat.b;
   assign alu_control   = alu_dat.ctrl;

   // One-deep response buffer; priority pointer only moves on an actual transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         last_grant <= 1'b1;
      end else if (grant_vld) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= grant_id;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
         last_grant <= grant_id;
      end else if (rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
// Latency: expects each accepted request to show on rsp_* one cycle later.
// Backpressure: exercises response stalls, async reset while stalled and both arbitration modes.
module tb_alu_share_arbiter;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_IDLE = 4'b1111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rsp_ready;

   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic [31:0] alu_operand_a, alu_operand_b, alu_result;
   logic [3:0]  alu_control;
   logic        alu_zero;
   logic        rsp_valid, rsp_id, rsp_zero;
   logic [31:0] rsp_result;

   logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
   logic [31:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b;
   logic [3:0]  f_req0_ctrl, f_req1_ctrl;
   logic [31:0] f_alu_operand_a, f_alu_operand_b, f_alu_result;
   logic [3:0]  f_alu_control;
   logic        f_alu_zero;
   logic        f_rsp_valid, f_rsp_id, f_rsp_zero;
   logic [31:0] f_rsp_result;

   typedef struct packed {
      logic        id;
      logic [31:0] res;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] c);
      case (c)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_XOR:  return a ^ b;
         OP_SUB:  return a - b;
         OP_SRA:  return $signed(a) >>> b[4:0];
         default: return 32'h0;
      endcase
   endfunction

   assign alu_result   = alu_model(alu_operand_a, alu_operand_b, alu_control);
   assign alu_zero     = (alu_result == 32'h0);
   assign f_alu_result = alu_model(f_alu_operand_a, f_alu_operand_b, f_alu_control);
   assign f_alu_zero   = (f_alu_result == 32'h0);

   alu_share_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ctrl(req1_ctrl),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_control(alu_control),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   alu_share_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .FIXED_PRIO(1'b1)) u_fix (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b),
      .req0_ctrl(f_req0_ctrl),
      .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b),
      .req1_ctrl(f_req1_ctrl),
      .alu_operand_a(f_alu_operand_a), .alu_operand_b(f_alu_operand_b), .alu_control(f_alu_control),
      .alu_result(f_alu_result), .alu_zero(f_alu_zero),
      .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id),
      .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Scoreboard: retire the buffered response first, then record newly accepted requests.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_id", {31'd0, rsp_id}, {31'd0, e.id});
               check("sb_result", rsp_result, e.res);
               check("sb_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
            end
         end
         if (req0_valid && req0_ready) begin
            logic [31:0] r;
            r = alu_model(req0_a, req0_b, req0_ctrl);
            sb.push_back('{id: 1'b0, res: r, zero: (r == 32'h0)});
         end
         if (req1_valid && req1_ready) begin
            logic [31:0] r;
            r = alu_model(req1_a, req1_b, req1_ctrl);
            sb.push_back('{id: 1'b1, res: r, zero: (r == 32'h0)});
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0_valid   = 1'b0;
      req1_valid   = 1'b0;
      f_req0_valid = 1'b0;
      f_req1_valid = 1'b0;
      rst_n        = 1'b0;
      sb.delete();
      next_cyc();
      rst_n = 1'b1;
   endtask

   task automatic load0();
      logic [3:0] ops [6];
      ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SRA};
      req0_a = $urandom; req0_b = $urandom; req0_ctrl = ops[$urandom_range(0, 5)];
   endtask

   task automatic load1();
      logic [3:0] ops [6];
      ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SRA};
      req1_a = $urandom; req1_b = $urandom; req1_ctrl = ops[$urandom_range(0, 5)];
   endtask

   initial begin
      logic [31:0] f_exp, f_exp_next;
      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = OP_ADD;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = OP_ADD;
      f_req0_valid = 1'b0; f_req0_a = '0; f_req0_b = '0; f_req0_ctrl = OP_ADD;
      f_req1_valid = 1'b0; f_req1_a = '0; f_req1_b = '0; f_req1_ctrl = OP_ADD;
      f_exp = '0; f_exp_next = '0;

      // Reset values
      @(negedge clk);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
      check("rst_alu_ctrl", {28'd0, alu_control}, {28'd0, OP_IDLE});
      next_cyc();
      rst_n = 1'b1;

      // 1: single ADD on port 0
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = OP_ADD;
      @(negedge clk);
      check("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
      check("t1_alu_a", alu_operand_a, 32'd5);
      check("t1_alu_ctrl", {28'd0, alu_control}, {28'd0, OP_ADD});
      next_cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("t1_rsp_id", {31'd0, rsp_id}, 32'd0);
      check("t1_rsp_result", rsp_result, 32'd8);
      check("t1_rsp_zero", {31'd0, rsp_zero}, 32'd0);

      // 2: simultaneous requests right after reset
      next_cyc();
      do_reset();
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = OP_ADD;
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_ctrl = OP_SUB;
      @(negedge clk);
      check("t2_n_rdy0", {31'd0, req0_ready}, 32'd1);
      check("t2_n_rdy1", {31'd0, req1_ready}, 32'd0);
      next_cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      check("t2_n1_result", rsp_result, 32'd2);
      check("t2_n1_id", {31'd0, rsp_id}, 32'd0);
      check("t2_n1_rdy1", {31'd0, req1_ready}, 32'd1);

      // 3: response stalled for 4 cycles while port 1 waits
      next_cyc();
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F; req1_ctrl = OP_OR;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("t3_hold_result", rsp_result, 32'd0);
         check("t3_hold_id", {31'd0, rsp_id}, 32'd1);
         check("t3_hold_zero", {31'd0, rsp_zero}, 32'd1);
         check("t3_hold_rdy0", {31'd0, req0_ready}, 32'd0);
         check("t3_hold_rdy1", {31'd0, req1_ready}, 32'd0);
         next_cyc();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t3_release_rdy1", {31'd0, req1_ready}, 32'd1);
      next_cyc();
      req1_valid = 1'b0;
      @(negedge clk);
      check("t3_new_result", rsp_result, 32'h0000_00FF);
      check("t3_new_id", {31'd0, rsp_id}, 32'd1);

      // 4a: round-robin under continuous contention
      next_cyc();
      do_reset();
      load0(); load1();
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         if (k < 6) begin
            check("t4_rr_rdy0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t4_rr_rdy1", {31'd0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         end
         if (k >= 1) begin
            check("t4_rr_valid", {31'd0, rsp_valid}, 32'd1);
            check("t4_rr_id", {31'd0, rsp_id}, ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
         end
         next_cyc();
         if (k == 5) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
         end else if (k < 5) begin
            if (k % 2 == 0) load0(); else load1();
         end
      end

      // 4b: fixed priority under continuous contention
      f_req0_a = $urandom; f_req0_b = $urandom; f_req0_ctrl = OP_ADD;
      f_req1_a = 32'd40; f_req1_b = 32'd2; f_req1_ctrl = OP_SUB;
      f_req0_valid = 1'b1; f_req1_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         f_exp_next = alu_model(f_req0_a, f_req0_b, f_req0_ctrl);
         check("t4_fp_rdy0", {31'd0, f_req0_ready}, 32'd1);
         check("t4_fp_rdy1", {31'd0, f_req1_ready}, 32'd0);
         if (k >= 1) begin
            check("t4_fp_valid", {31'd0, f_rsp_valid}, 32'd1);
            check("t4_fp_id", {31'd0, f_rsp_id}, 32'd0);
            check("t4_fp_result", f_rsp_result, f_exp);
            check("t4_fp_zero", {31'd0, f_rsp_zero}, (f_exp == 32'd0) ? 32'd1 : 32'd0);
         end
         f_exp = f_exp_next;
         next_cyc();
         f_req0_a = $urandom; f_req0_b = $urandom; f_req0_ctrl = (k % 2 == 0) ? OP_XOR : OP_SUB;
      end
      f_req0_valid = 1'b0;
      @(negedge clk);
      check("t4_fp_last_id", {31'd0, f_rsp_id}, 32'd0);
      check("t4_fp_last_result", f_rsp_result, f_exp);
      check("t4_fp_late_rdy1", {31'd0, f_req1_ready}, 32'd1);
      next_cyc();
      f_req1_valid = 1'b0;
      @(negedge clk);
      check("t4_fp_p1_id", {31'd0, f_rsp_id}, 32'd1);
      check("t4_fp_p1_result", f_rsp_result, 32'd38);

      // 5: async reset while a response is stalled
      next_cyc();
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_ctrl = OP_ADD;
      @(negedge clk);
      check("t5_rdy0", {31'd0, req0_ready}, 32'd1);
      next_cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      check("t5_stalled_valid", {31'd0, rsp_valid}, 32'd1);
      check("t5_stalled_result", rsp_result, 32'd10);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("t5_async_valid", {31'd0, rsp_valid}, 32'd0);
      check("t5_async_result", rsp_result, 32'd0);
      next_cyc();
      rst_n = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h1234_5678; req0_ctrl = OP_XOR;
      req1_valid = 1'b1; req1_a = 32'hFF00_FF00; req1_b = 32'h0F0F_0F0F; req1_ctrl = OP_AND;
      @(negedge clk);
      check("t5_post_rdy0", {31'd0, req0_ready}, 32'd1);
      check("t5_post_rdy1", {31'd0, req1_ready}, 32'd0);
      next_cyc();
      req0_valid = 1'b0;
      @(negedge clk);
      check("t5_post_zero", {31'd0, rsp_zero}, 32'd1);
      check("t5_post2_rdy1", {31'd0, req1_ready}, 32'd1);
      next_cyc();
      req1_valid = 1'b0;

      // 6: arithmetic right shift on port 1, ALU parked when idle
      req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'd4; req1_ctrl = OP_SRA;
      @(negedge clk);
      check("t6_rdy1", {31'd0, req1_ready}, 32'd1);
      check("t6_alu_ctrl", {28'd0, alu_control}, {28'd0, OP_SRA});
      next_cyc();
      req1_valid = 1'b0;
      @(negedge clk);
      check("t6_result", rsp_result, 32'hF800_0000);
      check("t6_id", {31'd0, rsp_id}, 32'd1);
      check("t6_idle_ctrl", {28'd0, alu_control}, {28'd0, OP_IDLE});
      check("t6_idle_a", alu_operand_a, 32'd0);
      check("t6_idle_b", alu_operand_b, 32'd0);
      next_cyc();
      @(negedge clk);
      check("t6_drained_valid", {31'd0, rsp_valid}, 32'd0);
      check("sb_leftover", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
